// File: rtl/branch_pkg.sv
// Shared types and constants for the bimodal branch predictor and the branch comparator.
package branch_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_GT = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

    function automatic logic [1:0] bp_sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != BP_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != BP_SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one combinational read port, one clocked update port.
module bp_counter_table
    import branch_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic                rd_taken_o,
    input  logic                upd_en_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] cnt_q [ENTRIES];

    // No bypass: a same-cycle update is seen by the read port one cycle later.
    assign rd_taken_o = cnt_q[rd_idx_i][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= BP_WNT;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= bp_sat_next(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor with misprediction redirect and flush sequencing.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int IDX_BITS     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fetch_pc,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic        resolve_pred,
    input  logic [15:0] resolve_target,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        flush,
`ifdef BP_STATS_EN
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts,
`endif
    output logic        busy
);

    bp_state_t   state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        accept, mispredict;
    logic        unused_fetch_hi;

    assign accept     = resolve_valid && (state_q == IDLE);
    assign mispredict = accept && (resolve_taken != resolve_pred);
    assign unused_fetch_hi = ^fetch_pc[15:IDX_BITS];

    bp_counter_table #(.IDX_BITS(IDX_BITS)) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (fetch_pc[IDX_BITS-1:0]),
        .rd_taken_o  (pred_taken),
        .upd_en_i    (accept),
        .upd_idx_i   (resolve_pc[IDX_BITS-1:0]),
        .upd_taken_i (resolve_taken)
    );

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    flush_cnt_d      = 4'(FLUSH_CYCLES - 1);
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = resolve_taken ? resolve_target : resolve_pc + 16'd1;
                    flush_d          = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'h0000;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = (state_q == FLUSH);

`ifdef BP_STATS_EN
    logic [15:0] br_cnt_q, mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= 16'd0;
            mis_cnt_q <= 16'd0;
        end else begin
            if (accept && br_cnt_q != 16'hFFFF)
                br_cnt_q <= br_cnt_q + 16'd1;
            if (mispredict && mis_cnt_q != 16'hFFFF)
                mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor and misprediction recovery unit for the 16-bit pipelined datapath. In fetch it supplies a taken/not-taken prediction for the current PC from a table of 2-bit saturating counters. In execute it consumes the resolved outcome from the branch comparator, trains the table, and on a misprediction issues a one-cycle PC redirect plus a multi-cycle pipeline flush. It is the consumer of the comparator's `out` signal, closing the loop between fetch and execute.

## Interface
- `IDX_BITS`, 4: table index width; the table has 2^IDX_BITS entries, indexed by `pc[IDX_BITS-1:0]`.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a misprediction (1..15).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_pc` in 16: PC in the fetch stage.
- `pred_taken` out 1: combinational prediction for `fetch_pc`, equal to the MSB of the indexed counter.
- `resolve_valid` in 1: a branch is resolving in execute this cycle.
- `resolve_pc` in 16: PC of the resolving branch.
- `resolve_taken` in 1: actual outcome, the branch comparator `out`.
- `resolve_pred` in 1: prediction that was carried down the pipeline with this branch.
- `resolve_target` in 16: branch target address.
- `redirect_valid` out 1: registered; high for one cycle to load `redirect_pc` into the PC.
- `redirect_pc` out 16: registered; the corrected PC.
- `flush` out 1: registered; squash IF/ID/EX wrong-path instructions.
- `busy` out 1: high while the FSM is in FLUSH.
- `stat_branches` out 16: present only with `BP_STATS_EN`.
- `stat_mispredicts` out 16: present only with `BP_STATS_EN`.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Every entry resets to 01.
- **Accepted resolve:** `resolve_valid` is high and the state is IDLE.
- On an accepted resolve, the entry at `resolve_pc[IDX_BITS-1:0]` saturates up if `resolve_taken` is 1, or down if it is 0. 11 stays 11 on taken; 00 stays 00 on not-taken.
- Misprediction is `resolve_taken != resolve_pred` on an accepted resolve.
- Corrected PC is `resolve_target` if taken, else `resolve_pc + 1`. The +1 is word-addressed, modulo 2^16, so 0xFFFF+1 wraps to 0x0000.
- **FSM states:** IDLE and FLUSH.
  - IDLE to FLUSH on a misprediction.
  - FLUSH to IDLE once the flush counter expires.
  - A correct prediction remains in IDLE with no outputs asserted.
- While in FLUSH, `resolve_valid` is ignored: wrong-path branches cause no table update, no stats, and no redirect.
- **Read/update collision:** when a fetch read and a table update hit the same index in the same cycle, `pred_taken` returns the pre-update value. There is no bypass.
- The `mode` encoding of the comparator (00 eq, 01 gt, 10 lt) is not consumed here. Only the outcome bit is used.

## Timing
- `pred_taken` has zero latency (combinational table read).
- **Misprediction resolved at cycle N:**
  - `redirect_valid` and `redirect_pc` are valid at N+1, for one cycle only.
  - `flush` is high during N+1 .. N+FLUSH_CYCLES.
  - `busy` is high over the same window.
  - The state returns to IDLE at N+FLUSH_CYCLES+1, where a new resolve is accepted.
- The table update is visible to fetch reads from N+1.
- **Reset values:** `redirect_valid`=0, `redirect_pc`=0x0000, `flush`=0, `busy`=0, FSM=IDLE, flush counter=0, all counters=01, stats=0.
- Reset asserted mid-flush aborts immediately: every output takes its reset value asynchronously.
- `redirect_pc` holds its last value when `redirect_valid` is low.

## Configuration
- **Macro `BP_STATS_EN`:**
  - Defined: `stat_branches` increments on every accepted resolve, and `stat_mispredicts` increments on every misprediction. Both saturate at 0xFFFF and reset to 0.
  - Undefined: both ports and their counters are absent. Predictor behaviour is identical in both cases.

## Structure
- **Package `branch_pkg`:**
  - Counter state constants: `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`.
  - FSM state typedef `bp_state_t` {IDLE, FLUSH}.
  - Comparator mode constants `BR_EQ`, `BR_GT`, `BR_LT`, so the comparator and the decoder share them.
- **Sub-module `bp_counter_table`:**
  - Parameterized by `IDX_BITS`.
  - One asynchronous read port and one synchronous saturating-update port.
  - Asynchronous reset of all entries to 01.
- The top level holds the FSM, flush counter, redirect registers, and optional stats.

## Test plan
- **Reset read:** reset, then sweep `fetch_pc` over 0x0000..0x000F. `pred_taken`=0 for all 16 entries.
- **Training:** three accepted taken resolves at pc 0x0005 with `resolve_pred` matching. `pred_taken`@0x0005 becomes 1 after the first resolve. The counter saturates at 11; one not-taken leaves the prediction at 1, and a second drives it to 0.
- **Misprediction, not-taken predicted:** pc=0x0010, pred=0, taken=1, target=0x0040 at cycle N. `redirect_valid`=1 and `redirect_pc`=0x0040 at N+1 only. `flush` is high at N+1..N+2.
- **Misprediction, taken predicted, wrap:** pc=0xFFFF, pred=1, taken=0. `redirect_pc`=0x0000.
- **Squash during flush:** `resolve_valid` is pulsed with a mismatch at N+1. No second redirect, the table is unchanged, and `stat_mispredicts`=1 with `BP_STATS_EN`.
- **Reset during flush:** assert `rst_n`=0 at N+1. `flush`, `busy` and `redirect_valid` drop to 0 immediately, and all counters read 01 after release.
